// File: rtl/dp_dtm.sv
// JTAG debug transport: 16-state TAP, parametrised IR, IDCODE/DTMCS/DMI/BYPASS registers.
// DMI scans become valid/ready requests; responses update the captured status.
module dp_dtm #(
  parameter int unsigned ABITS     = 7,
  parameter int unsigned IR_LEN    = 5,
  parameter logic [31:0] IDCODE    = 32'h1000_700F,
  parameter int unsigned IDLE_HINT = 1
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_en,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_rsp_valid,
  output logic             dmi_rsp_ready,
  input  logic [31:0]      dmi_rsp_data,
  input  logic [1:0]       dmi_rsp_op
);

  localparam int unsigned DRW = ABITS + 34;
  localparam logic [IR_LEN-1:0] IR_IDC = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] IR_DTM = IR_LEN'(16);
  localparam logic [IR_LEN-1:0] IR_DMI = IR_LEN'(17);
  localparam logic [2:0] IDLE3 = 3'(IDLE_HINT);
  localparam logic [5:0] ABITS6 = 6'(ABITS);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  typedef enum logic [1:0] {DR_BYP, DR_IDC, DR_DTM, DR_DMI} dr_sel_e;

  tap_e              state_q, state_d;
  logic [IR_LEN-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [DRW-1:0]    dr_sr_q, dr_sr_d;
  logic              req_vld_q, req_vld_d;
  logic [ABITS-1:0]  addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        op_q, op_d;
  logic              busy_q, busy_d;
  logic [1:0]        stat_q, stat_d;
  logic [31:0]       rdata_q, rdata_d;
  dr_sel_e           dr_sel;
  logic [1:0]        dmi_status;
  logic [1:0]        upd_op;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms ? TLR    : RTI;
      RTI:     state_d = tms ? SEL_DR : RTI;
      SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms ? SEL_DR : RTI;
      SEL_IR:  state_d = tms ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    dr_sel = DR_BYP;
    if (ir_q == IR_IDC)      dr_sel = DR_IDC;
    else if (ir_q == IR_DTM) dr_sel = DR_DTM;
    else if (ir_q == IR_DMI) dr_sel = DR_DMI;
  end

  assign dmi_status = (stat_q != 2'd0) ? stat_q : (busy_q ? 2'd3 : 2'd0);
  assign upd_op     = dr_sr_q[1:0];

  always_comb begin
    ir_d      = ir_q;
    ir_sr_d   = ir_sr_q;
    dr_sr_d   = dr_sr_q;
    req_vld_d = req_vld_q;
    addr_d    = addr_q;
    data_d    = data_q;
    op_d      = op_q;
    busy_d    = busy_q;
    stat_d    = stat_q;
    rdata_d   = rdata_q;

    case (state_q)
      TLR:    ir_d = IR_IDC;
      CAP_IR: ir_sr_d = IR_LEN'(1);
      SH_IR:  ir_sr_d = {tdi, ir_sr_q[IR_LEN-1:1]};
      UPD_IR: ir_d = ir_sr_q;
      CAP_DR: begin
        dr_sr_d = '0;
        case (dr_sel)
          DR_IDC:  dr_sr_d[31:0] = IDCODE;
          DR_DTM:  dr_sr_d[31:0] = {14'b0, 3'b0, IDLE3, stat_q, ABITS6, 4'd1};
          DR_DMI:  dr_sr_d = {addr_q, rdata_q, dmi_status};
          default: dr_sr_d = '0;
        endcase
      end
      SH_DR: begin
        case (dr_sel)
          DR_IDC, DR_DTM: dr_sr_d = {{(DRW-32){1'b0}}, tdi, dr_sr_q[31:1]};
          DR_DMI:         dr_sr_d = {tdi, dr_sr_q[DRW-1:1]};
          default:        dr_sr_d = {{(DRW-1){1'b0}}, tdi};
        endcase
      end
      default: ;
    endcase

    // Handshakes resolve before any Update-DR on the same edge sees busy/dmistat.
    if (req_vld_q && dmi_req_ready) req_vld_d = 1'b0;
    if (dmi_rsp_valid && busy_q) begin
      rdata_d = dmi_rsp_data;
      busy_d  = 1'b0;
      if (dmi_rsp_op[1] && stat_q == 2'd0) stat_d = dmi_rsp_op;
    end

    if (state_q == UPD_DR) begin
      if (dr_sel == DR_DTM) begin
        if (dr_sr_q[16]) stat_d = 2'd0;
        if (dr_sr_q[17]) begin
          stat_d    = 2'd0;
          busy_d    = 1'b0;
          req_vld_d = 1'b0;
        end
      end else if (dr_sel == DR_DMI && (upd_op == 2'd1 || upd_op == 2'd2)) begin
        if (stat_d != 2'd0) begin
          stat_d = stat_d;
        end else if (busy_d) begin
          stat_d = 2'd3;
        end else begin
          addr_d    = dr_sr_q[DRW-1:34];
          data_d    = dr_sr_q[33:2];
          op_d      = upd_op;
          req_vld_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state_q   <= TLR;
      ir_q      <= IR_IDC;
      ir_sr_q   <= '0;
      dr_sr_q   <= '0;
      req_vld_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= '0;
      busy_q    <= 1'b0;
      stat_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ir_sr_q   <= ir_sr_d;
      dr_sr_q   <= dr_sr_d;
      req_vld_q <= req_vld_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      stat_q    <= stat_d;
      rdata_q   <= rdata_d;
    end
  end

  assign tdo_en        = (state_q == SH_DR) || (state_q == SH_IR);
  assign tdo           = !tdo_en ? 1'b0 : ((state_q == SH_IR) ? ir_sr_q[0] : dr_sr_q[0]);
  assign dmi_req_valid = req_vld_q;
  assign dmi_req_addr  = addr_q;
  assign dmi_req_data  = data_q;
  assign dmi_req_op    = op_q;
  assign dmi_rsp_ready = 1'b1;

endmodule

// File: tb/tb_dp_dtm.sv
// Bench for dp_dtm: queue-based TAP/DMI model compared every cycle, plus literal scan results.
module tb_dp_dtm;
  localparam int ABITS = 7;
  localparam int IR_LEN = 5;
  localparam logic [31:0] IDC = 32'h1000_700F;
  localparam int IDLE_HINT = 1;
  localparam int DRW = ABITS + 34;

  localparam int S_TLR = 0, S_RTI = 1, S_SDR = 2, S_CDR = 3, S_SHDR = 4, S_E1DR = 5,
                 S_PDR = 6, S_E2DR = 7, S_UDR = 8, S_SIR = 9, S_CIR = 10, S_SHIR = 11,
                 S_E1IR = 12, S_PIR = 13, S_E2IR = 14, S_UIR = 15;

  logic tck = 1'b0;
  logic trst, tms, tdi, tdo, tdo_en;
  logic dmi_req_valid, dmi_req_ready, dmi_rsp_valid, dmi_rsp_ready;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0] dmi_req_data, dmi_rsp_data;
  logic [1:0] dmi_req_op, dmi_rsp_op;

  always #5 tck = ~tck;

  dp_dtm #(.ABITS(ABITS), .IR_LEN(IR_LEN), .IDCODE(IDC), .IDLE_HINT(IDLE_HINT)) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
    .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state
  int               m_st;
  logic [IR_LEN-1:0] m_ir;
  bit               m_irq[$];
  bit               m_drq[$];
  logic             m_vld, m_busy;
  logic [ABITS-1:0] m_addr;
  logic [31:0]      m_data, m_rdata;
  logic [1:0]       m_op, m_stat;

  function automatic int tap_next(input int s, input logic t);
    case (s)
      S_TLR:  return t ? S_TLR : S_RTI;
      S_RTI:  return t ? S_SDR : S_RTI;
      S_SDR:  return t ? S_SIR : S_CDR;
      S_CDR:  return t ? S_E1DR : S_SHDR;
      S_SHDR: return t ? S_E1DR : S_SHDR;
      S_E1DR: return t ? S_UDR : S_PDR;
      S_PDR:  return t ? S_E2DR : S_PDR;
      S_E2DR: return t ? S_UDR : S_SHDR;
      S_UDR:  return t ? S_SDR : S_RTI;
      S_SIR:  return t ? S_TLR : S_CIR;
      S_CIR:  return t ? S_E1IR : S_SHIR;
      S_SHIR: return t ? S_E1IR : S_SHIR;
      S_E1IR: return t ? S_UIR : S_PIR;
      S_PIR:  return t ? S_E2IR : S_PIR;
      S_E2IR: return t ? S_UIR : S_SHIR;
      default: return t ? S_SDR : S_RTI;
    endcase
  endfunction

  task automatic model_reset();
    m_st = S_TLR; m_ir = 1; m_irq = {}; m_drq = {};
    m_vld = 0; m_busy = 0; m_addr = 0; m_data = 0; m_rdata = 0; m_op = 0; m_stat = 0;
  endtask

  task automatic load_q(input logic [127:0] v, input int n, input bit is_ir);
    if (is_ir) m_irq = {}; else m_drq = {};
    for (int i = 0; i < n; i++) if (is_ir) m_irq.push_back(v[i]); else m_drq.push_back(v[i]);
  endtask

  task automatic model_edge();
    logic [127:0] v;
    logic [1:0] st_code;
    v = '0;
    if (m_vld && dmi_req_ready) m_vld = 0;
    if (dmi_rsp_valid && m_busy) begin
      m_rdata = dmi_rsp_data; m_busy = 0;
      if (dmi_rsp_op >= 2 && m_stat == 0) m_stat = dmi_rsp_op;
    end
    case (m_st)
      S_TLR: m_ir = 1;
      S_CIR: load_q(128'd1, IR_LEN, 1);
      S_SHIR: begin void'(m_irq.pop_front()); m_irq.push_back(tdi); end
      S_UIR: begin
        for (int i = 0; i < IR_LEN; i++) v[i] = m_irq[i];
        m_ir = v[IR_LEN-1:0];
      end
      S_CDR: begin
        if (m_ir == 1) load_q({96'd0, IDC}, 32, 0);
        else if (m_ir == 16) load_q((IDLE_HINT << 12) + (m_stat << 10) + (ABITS << 4) + 1, 32, 0);
        else if (m_ir == 17) begin
          st_code = (m_stat != 0) ? m_stat : (m_busy ? 2'd3 : 2'd0);
          load_q((128'(m_addr) << 34) + (128'(m_rdata) << 2) + 128'(st_code), DRW, 0);
        end else load_q(128'd0, 1, 0);
      end
      S_SHDR: begin void'(m_drq.pop_front()); m_drq.push_back(tdi); end
      S_UDR: begin
        for (int i = 0; i < m_drq.size(); i++) v[i] = m_drq[i];
        if (m_ir == 16) begin
          if (v[16]) m_stat = 0;
          if (v[17]) begin m_stat = 0; m_busy = 0; m_vld = 0; end
        end else if (m_ir == 17 && (v[1:0] == 1 || v[1:0] == 2)) begin
          if (m_stat != 0) m_stat = m_stat;
          else if (m_busy) m_stat = 3;
          else begin
            m_addr = v[34 +: ABITS]; m_data = v[33:2]; m_op = v[1:0];
            m_vld = 1; m_busy = 1;
          end
        end
      end
      default: ;
    endcase
    m_st = tap_next(m_st, tms);
  endtask

  always @(negedge tck) begin
    logic en_e, tdo_e;
    if (chk_en) begin
      en_e  = (m_st == S_SHDR) || (m_st == S_SHIR);
      tdo_e = 1'b0;
      if (m_st == S_SHDR && m_drq.size() > 0) tdo_e = m_drq[0];
      if (m_st == S_SHIR && m_irq.size() > 0) tdo_e = m_irq[0];
      chk("tdo_en", tdo_en, en_e);
      chk("tdo", tdo, tdo_e);
      chk("req_valid", dmi_req_valid, m_vld);
      chk("req_addr", dmi_req_addr, m_addr);
      chk("req_data", dmi_req_data, m_data);
      chk("req_op", dmi_req_op, m_op);
      chk("rsp_ready", dmi_rsp_ready, 1'b1);
    end
  end

  task automatic step(input logic t, input logic d);
    tms = t; tdi = d;
    @(posedge tck); #1;
    model_edge();
  endtask

  task automatic scan_ir(input logic [IR_LEN-1:0] v);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IR_LEN; i++) step(i == IR_LEN - 1, v[i]);
    step(1, 0); step(0, 0);
  endtask

  task automatic scan_dr(input int len, input logic [127:0] din, output logic [127:0] dout);
    dout = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < len; i++) begin
      dout[i] = tdo;
      step(i == len - 1, din[i]);
    end
    step(1, 0); step(0, 0);
  endtask

  task automatic respond(input logic [1:0] op, input logic [31:0] d);
    dmi_rsp_valid = 1; dmi_rsp_op = op; dmi_rsp_data = d;
    step(0, 0);
    dmi_rsp_valid = 0; dmi_rsp_op = 0; dmi_rsp_data = 0;
  endtask

  logic [127:0] o;

  initial begin
    trst = 1; tms = 1; tdi = 0; dmi_req_ready = 0;
    dmi_rsp_valid = 0; dmi_rsp_data = 0; dmi_rsp_op = 0;
    model_reset();
    @(posedge tck); #1;
    chk_en = 1;
    chk("rst_tdo", tdo, 1'b0);
    chk("rst_tdo_en", tdo_en, 1'b0);
    chk("rst_req_valid", dmi_req_valid, 1'b0);
    chk("rst_rsp_ready", dmi_rsp_ready, 1'b1);
    @(posedge tck); #1;
    trst = 0;
    step(0, 0);

    scan_dr(32, 0, o);
    chk("idcode", o[31:0], 32'h1000700F);
    scan_ir(5'h10);
    scan_dr(32, 0, o);
    chk("dtmcs", o[31:0], 32'h00001071);

    // DMI write with ready held low for 3 edges
    scan_ir(5'h11);
    scan_dr(DRW, {7'h10, 32'hDEADBEEF, 2'd2}, o);
    chk("dmi_cap0", o, 128'd0);
    chk("wr_valid", dmi_req_valid, 1'b1);
    chk("wr_fields", {dmi_req_addr, dmi_req_data, dmi_req_op}, {7'h10, 32'hDEADBEEF, 2'd2});
    step(0, 0); step(0, 0); step(0, 0);
    chk("wr_hold", dmi_req_valid, 1'b1);
    dmi_req_ready = 1;
    step(0, 0);
    chk("wr_accepted", dmi_req_valid, 1'b0);
    respond(2'd0, 32'h12345678);
    scan_dr(DRW, 0, o);
    chk("dmi_cap_ok", o, {7'h10, 32'h12345678, 2'd0});

    // Read while busy -> sticky busy status, further reads ignored
    scan_dr(DRW, {7'h05, 32'h0, 2'd1}, o);
    scan_dr(DRW, {7'h06, 32'h0, 2'd1}, o);
    chk("cap_busy", o, {7'h05, 32'h12345678, 2'd3});
    scan_dr(DRW, {7'h07, 32'h0, 2'd1}, o);
    chk("cap_sticky", o, {7'h05, 32'h12345678, 2'd3});
    chk("ignored_addr", dmi_req_addr, 7'h05);
    respond(2'd0, 32'hCAFEF00D);
    scan_ir(5'h10);
    scan_dr(32, 32'h00010000, o);
    chk("dtmcs_stat3", o[31:0], 32'h00001C71);
    scan_ir(5'h11);
    scan_dr(DRW, {7'h08, 32'h0, 2'd1}, o);
    chk("cap_cleared", o, {7'h05, 32'hCAFEF00D, 2'd0});
    chk("rd_reissue", dmi_req_valid, 1'b1);
    step(0, 0);

    // Failed response, dmireset, then dmihardreset with request pending
    respond(2'd2, 32'h0BADF00D);
    scan_ir(5'h10);
    scan_dr(32, 32'h00010000, o);
    chk("dtmcs_stat2", o[31:0], 32'h00001871);
    scan_ir(5'h11);
    dmi_req_ready = 0;
    scan_dr(DRW, {7'h09, 32'h0, 2'd1}, o);
    chk("pending", dmi_req_valid, 1'b1);
    scan_ir(5'h10);
    scan_dr(32, 32'h00020000, o);
    chk("dtmcs_pre_hard", o[31:0], 32'h00001071);
    chk("hard_drop", dmi_req_valid, 1'b0);
    scan_ir(5'h11);
    scan_dr(DRW, 0, o);
    chk("cap_after_hard", o, {7'h09, 32'h0BADF00D, 2'd0});

    // Bypass: one-cycle delay
    scan_ir(5'h05);
    scan_dr(8, 8'hA5, o);
    chk("bypass", o[7:0], 8'h4A);

    // Test-Logic-Reset via tms mid Shift-DR keeps the pending request
    scan_ir(5'h11);
    scan_dr(DRW, {7'h0A, 32'h55AA55AA, 2'd2}, o);
    step(1, 0); step(0, 0); step(0, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("tms_reset_tdo_en", tdo_en, 1'b0);
    step(0, 0);
    chk("tms_reset_valid", dmi_req_valid, 1'b1);
    scan_dr(32, 0, o);
    chk("ir_after_tlr", o[31:0], 32'h1000700F);

    // trst clears the outstanding transaction; late response discarded
    trst = 1;
    model_reset();
    #1;
    chk("trst_valid", dmi_req_valid, 1'b0);
    @(posedge tck); #1;
    trst = 0;
    respond(2'd2, 32'hFFFF0000);
    scan_ir(5'h11);
    scan_dr(DRW, 0, o);
    chk("late_rsp_dropped", o, 128'd0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dp_dtm.md
# dp_dtm

Parametrised JTAG debug transport module: the successor to the fixed-width debug access port. Contains its own 16-state TAP controller and a parametrised instruction register. It holds IDCODE, DTMCS, DMI and BYPASS data registers, and turns DMI scans into valid/ready request/response transactions towards a debug module. Everything runs on tck. Capture, shift and update are state-qualified register writes, not gated clocks.

## Interface
- ABITS, 7: DMI address width (1..63).
- IR_LEN, 5: instruction register length (≥5).
- IDCODE, 32'h1000_700F: IDCODE register value.
- IDLE_HINT, 1: value reported in dtmcs.idle (3 bits).
- tck  in  1  test clock; the only clock.
- trst  in  1  asynchronous, active-high reset.
- tms  in  1  test mode select.
- tdi  in  1  test data input.
- tdo  out  1  test data output.
- tdo_en  out  1  high in Shift-DR/Shift-IR only.
- dmi_req_valid  out  1  request valid.
- dmi_req_ready  in  1  debug module accepts request.
- dmi_req_addr  out  ABITS  request address.
- dmi_req_data  out  32  write data.
- dmi_req_op  out  2  1 = read, 2 = write.
- dmi_rsp_valid  in  1  response valid.
- dmi_rsp_ready  out  1  constant 1.
- dmi_rsp_data  in  32  read data.
- dmi_rsp_op  in  2  0 = ok, 2 = failed, 3 = busy.

## Operation
- TAP: standard IEEE 1149.1 16-state FSM, advanced on the tck rising edge by tms. trst forces Test-Logic-Reset. Five tms=1 cycles reach Test-Logic-Reset from any state.
- Instruction register:
  - In Test-Logic-Reset the IR loads 0x01 (IDCODE).
  - Capture-IR loads the IR shift register with ...0001.
  - Update-IR copies the shift register to the IR.
- IR decode: 0x01 IDCODE (32 bits), 0x10 DTMCS (32 bits), 0x11 DMI (ABITS+34 bits), all-ones BYPASS (1 bit). Any other code selects BYPASS.
- Shift: each Shift-xR edge shifts tdi into the MSB and right-shifts. tdo = shift register bit 0.
- BYPASS captures 0.
- DTMCS capture value: {14'b0, 1'b0 dmihardreset, 1'b0 dmireset, 1'b0, IDLE_HINT[2:0], dmistat[1:0], ABITS[5:0], 4'd1}.
- DTMCS update:
  - Bit 16 (dmireset) clears dmistat.
  - Bit 17 (dmihardreset) clears dmistat and busy, and drops dmi_req_valid.
- DMI register layout: {addr[ABITS-1:0], data[31:0], op[1:0]}.
- DMI capture: {last addr, last response data, status}. Status is dmistat if nonzero, else 3 if busy, else 0.
- DMI update when op is 1 or 2:
  - If dmistat≠0: ignored.
  - Else if busy: dmistat←3 and the request is dropped.
  - Else: latch addr, data and op; set dmi_req_valid and busy.
- DMI update with op 0 or 3: no action.
- Request handshake: dmi_req_valid and its fields hold until an edge with dmi_req_ready=1. Valid deasserts on that edge. busy stays set.
- Response handshake, when dmi_rsp_valid=1 and busy=1:
  - Store dmi_rsp_data as the last response data and clear busy.
  - If dmi_rsp_op≥2, set dmistat to dmi_rsp_op, unless dmistat is already nonzero.
- A response arriving with busy=0 is discarded.
- Test-Logic-Reset via tms resets the TAP and IR only. DMI state (busy, dmistat, request) survives.

## Timing
- All state changes happen on the tck rising edge.
- tdo and tdo_en are combinational from the current state and shift register, so they are valid for the whole cycle after the edge. tdo=0 when tdo_en=0.
- Shift register loads on the edge leaving Capture-xR. It shifts on each edge while in Shift-xR, including the edge that exits to Exit1.
- dmi_req_valid rises on the edge leaving Update-DR, i.e. 1 cycle of latency.
- A request and a response may complete on the same edge as a new Update-DR. The handshake results are applied first, then the update check.
- Reset values: TAP Test-Logic-Reset, IR 0x01, tdo 0, tdo_en 0, dmi_req_valid 0, dmi_req_addr/data/op 0, dmi_rsp_ready 1, busy 0, dmistat 0, last response data 0.
- trst during an outstanding transaction clears it immediately. Later responses are discarded.

## Test plan
- trst pulse, then scan DR 32 bits -> tdo LSB-first 0x1000700F. tdo_en high only during Shift-DR.
- Scan IR=0x10, then scan DR 32 bits -> 0x00001071.
- IR=0x11; scan addr 0x10, data 0xDEADBEEF, op 2; hold dmi_req_ready low 3 edges -> dmi_req_valid rises 1 cycle after Update-DR and the fields stay stable until ready. Then return rsp op 0 -> the next DMI capture shows op 0.
- Read issued while busy -> capture shows op 3. Further reads are ignored. dtmcs write 0x00010000 -> dmistat 0, and the next read issues.
- Response op 2 -> DTMCS capture dmistat=2. dtmcs write 0x00020000 with a request pending -> dmi_req_valid drops and dmistat becomes 0.
- IR=0x05 -> 1-cycle tdi-to-tdo bypass delay. 5× tms=1 mid-Shift-DR -> Test-Logic-Reset, IR=0x01, pending dmi_req_valid still asserted.
